mm_c_writer: RTL and testbench

- Result-writeback stage of the systolic matrix multiplier; sits directly downstream of the array/accumulator drain.
- Consumes one tile of ACCW-bit results as a row-major element stream.
- Packs elements into HOST_DW-bit words with the correct byte lanes.
- Issues single-beat Avalon-MM writes of matrix C to memory (byte addressing, row stride ldc).

---
 rtl/mm_c_writer.sv | 191 +++++++++++++++++++
 tb/tb_mm_c_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_c_writer.sv
// mm_c_writer: result-writeback stage of the systolic matrix multiplier.
// Packs a row-major stream of ACCW-bit tile results into HOST_DW-bit words
// and issues single-beat Avalon-MM writes of matrix C (byte addressed,
// row stride ldc elements).
// Optional: define MM_CW_STATS_EN to add the wr_beats accepted-write counter.
module mm_c_writer #(
  parameter int unsigned ACCW    = 32,
  parameter int unsigned HOST_DW = 128,
  parameter int unsigned T       = 4,
  parameter int unsigned DIMW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tile_start,
  input  logic [31:0]            baseC,
  input  logic [DIMW-1:0]        ldc,
  input  logic [DIMW-1:0]        row0,
  input  logic [DIMW-1:0]        col0,
  input  logic [DIMW-1:0]        rows,
  input  logic [DIMW-1:0]        cols,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACCW-1:0]        in_data,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            avm_address,
  output logic                   avm_write,
  output logic [HOST_DW-1:0]     avm_writedata,
  output logic [HOST_DW/8-1:0]   avm_byteenable,
  output logic [7:0]             avm_burstcount,
  input  logic                   avm_waitrequest
`ifdef MM_CW_STATS_EN
  ,
  output logic [31:0]            wr_beats
`endif
);

  localparam int unsigned EB    = ACCW / 8;
  localparam int unsigned LANES = HOST_DW / ACCW;
  localparam int unsigned WB    = HOST_DW / 8;
  localparam int unsigned CW    = $clog2(T + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         base_q, base_d;
  logic [DIMW-1:0]     ldc_q, ldc_d;
  logic [DIMW-1:0]     row0_q, row0_d;
  logic [DIMW-1:0]     col0_q, col0_d;
  logic [DIMW-1:0]     rows_q, rows_d;
  logic [DIMW-1:0]     cols_q, cols_d;
  logic [CW-1:0]       r_q, r_d;
  logic [CW-1:0]       c_q, c_d;
  logic [31:0]         addr_q, addr_d;
  logic [HOST_DW-1:0]  wdata_q, wdata_d;
  logic [WB-1:0]       be_q, be_d;

  logic [31:0]         elem_idx;
  logic [31:0]         byte_addr;
  logic [31:0]         lane;
  logic                last_col;
  logic                last_row;

  // Element address of (r, c) and its lane within the host word
  always_comb begin
    elem_idx  = (32'(row0_q) + 32'(r_q)) * 32'(ldc_q) + 32'(col0_q) + 32'(c_q);
    byte_addr = base_q + elem_idx * 32'(EB);
    lane      = (byte_addr / 32'(EB)) % 32'(LANES);
    last_col  = (DIMW'(c_q) == cols_q - DIMW'(1));
    last_row  = (DIMW'(r_q) == rows_q - DIMW'(1));
  end

  // Next-state, staging and handshake logic
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    ldc_d     = ldc_q;
    row0_d    = row0_q;
    col0_d    = col0_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    r_d       = r_q;
    c_d       = c_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    avm_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tile_start) begin
          base_d  = baseC & ~32'(EB - 1);
          ldc_d   = ldc;
          row0_d  = row0;
          col0_d  = col0;
          rows_d  = rows;
          cols_d  = cols;
          r_d     = '0;
          c_d     = '0;
          state_d = (rows == '0 || cols == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          wdata_d[lane*ACCW +: ACCW] = in_data;
          be_d[lane*EB +: EB]        = '1;
          addr_d                     = byte_addr & ~32'(WB - 1);
          if (lane == 32'(LANES - 1) || last_col) state_d = S_WRITE;
          else                                    c_d     = c_q + CW'(1);
        end
      end
      S_WRITE: begin
        avm_write = 1'b1;
        busy      = 1'b1;
        if (!avm_waitrequest) begin
          wdata_d = '0;
          be_d    = '0;
          if (last_row && last_col) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COLLECT;
            if (last_col) begin
              r_d = r_q + CW'(1);
              c_d = '0;
            end else begin
              c_d = c_q + CW'(1);
            end
          end
        end
      end
      default: begin
        done    = 1'b1;
        busy    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and staging registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      ldc_q   <= '0;
      row0_q  <= '0;
      col0_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ldc_q   <= ldc_d;
      row0_q  <= row0_d;
      col0_q  <= col0_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      r_q     <= r_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign avm_burstcount = 8'd1;

`ifdef MM_CW_STATS_EN
  logic [31:0] wr_beats_q;

  // Saturating count of accepted Avalon writes since reset
  always_ff @(posedge clk) begin
    if (!rst_n)                                               wr_beats_q <= '0;
    else if (avm_write && !avm_waitrequest && wr_beats_q != '1) wr_beats_q <= wr_beats_q + 32'd1;
  end

  assign wr_beats = wr_beats_q;
`endif

endmodule

// File: tb/tb_mm_c_writer.sv
// Directed testbench for mm_c_writer (default build, ACCW=32, HOST_DW=128).
module tb_mm_c_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tile_start;
  logic [31:0]  baseC;
  logic [15:0]  ldc, row0, col0, rows, cols;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         busy, done;
  logic [31:0]  avm_address;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic [7:0]   avm_burstcount;
  logic         avm_waitrequest;

  int total = 0;
  int bad   = 0;

  logic [31:0]  wa  [16];
  logic [127:0] wd  [16];
  logic [15:0]  wbe [16];
  int nwr, done_cnt, done_cyc, last_wr_cyc, timed_out, stall_viol, stall_cycles;

  always #5 clk = ~clk;

  mm_c_writer #(.ACCW(32), .HOST_DW(128), .T(4), .DIMW(16)) dut (
    .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .baseC(baseC),
    .ldc(ldc), .row0(row0), .col0(col0), .rows(rows), .cols(cols),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest)
  );

  // Expected word for row r of a 4x4 tile holding 1..16 row-major
  function automatic logic [127:0] row_word(input int r);
    return {32'(4*r+4), 32'(4*r+3), 32'(4*r+2), 32'(4*r+1)};
  endfunction

  // Drives one tile (elements 1..rows*cols) and logs every accepted write.
  // cyc counts rising edges since tile_start was sampled.
  task automatic run_tile(input logic [31:0] b, input logic [15:0] l, input logic [15:0] r0,
                          input logic [15:0] c0, input logic [15:0] nr, input logic [15:0] nc,
                          input int stall_idx, input int stall_len);
    int n, idx, cyc, left;
    bit held, accept;
    logic [31:0]  ha;
    logic [127:0] hd;
    logic [15:0]  hb;
    n = int'(nr) * int'(nc); idx = 0; left = stall_len; held = 0;
    ha = '0; hd = '0; hb = '0;
    nwr = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
    timed_out = 0; stall_viol = 0; stall_cycles = 0;
    @(negedge clk);
    baseC = b; ldc = l; row0 = r0; col0 = c0; rows = nr; cols = nc;
    tile_start = 1'b1;
    @(negedge clk);
    tile_start = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      in_valid = (idx < n);
      in_data  = 32'(idx + 1);
      avm_waitrequest = 1'b0;
      if (avm_write && nwr == stall_idx && left > 0) begin
        avm_waitrequest = 1'b1;
        if (!held) begin
          ha = avm_address; hd = avm_writedata; hb = avm_byteenable; held = 1;
        end else if (avm_address !== ha || avm_writedata !== hd || avm_byteenable !== hb) begin
          stall_viol++;
        end
        if (in_ready !== 1'b0) stall_viol++;
        left--;
        stall_cycles++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (avm_write === 1'b1 && !avm_waitrequest) begin
        if (nwr < 16) begin
          wa[nwr] = avm_address; wd[nwr] = avm_writedata; wbe[nwr] = avm_byteenable;
        end
        last_wr_cyc = cyc;
        nwr++;
      end
      accept = in_valid && (in_ready === 1'b1);
      @(posedge clk);
      if (accept) idx++;
      @(negedge clk);
      cyc++;
      if (done_cnt > 0 && cyc > done_cyc + 3) break;
    end
    if (done_cnt == 0) timed_out = 1;
    in_valid = 1'b0;
    avm_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, busy, done, avm_write} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got %b want 0000", {in_ready, busy, done, avm_write});
    end
    total++;
    if (avm_address !== 32'h0 || avm_writedata !== 128'h0 || avm_byteenable !== 16'h0) begin
      bad++; $display("FAIL reset_bus got addr=%h data=%h be=%h want all zero",
                      avm_address, avm_writedata, avm_byteenable);
    end
    total++;
    if (avm_burstcount !== 8'd1) begin
      bad++; $display("FAIL reset_burstcount got %0d want 1", avm_burstcount);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_aligned();
    run_tile(32'h3000, 16'd8, 16'd0, 16'd0, 16'd4, 16'd4, -1, 0);
    total++;
    if (timed_out != 0 || nwr != 4) begin
      bad++; $display("FAIL aligned_count got writes=%0d timeout=%0d want 4/0", nwr, timed_out);
    end
    for (int i = 0; i < 4 && i < nwr; i++) begin
      total++;
      if (wa[i] !== 32'h3000 + 32'(32*i) || wbe[i] !== 16'hFFFF || wd[i] !== row_word(i)) begin
        bad++; $display("FAIL aligned_w%0d got %h/%h/%h want %h/ffff/%h", i, wa[i], wbe[i], wd[i],
                        32'h3000 + 32'(32*i), row_word(i));
      end
    end
    total++;
    if (done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin
      bad++; $display("FAIL aligned_done got pulses=%0d at=%0d want 1 at %0d",
                      done_cnt, done_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_col_offset();
    run_tile(32'h3000, 16'd8, 16'd0, 16'd4, 16'd4, 16'd4, -1, 0);
    total++;
    if (timed_out != 0 || nwr != 4) begin
      bad++; $display("FAIL coloff_count got writes=%0d timeout=%0d want 4/0", nwr, timed_out);
    end
    for (int i = 0; i < 4 && i < nwr; i++) begin
      total++;
      if (wa[i] !== 32'h3010 + 32'(32*i) || wbe[i] !== 16'hFFFF || wd[i] !== row_word(i)) begin
        bad++; $display("FAIL coloff_w%0d got %h/%h/%h want %h/ffff/%h", i, wa[i], wbe[i], wd[i],
                        32'h3010 + 32'(32*i), row_word(i));
      end
    end
  endtask

  task automatic test_misaligned();
    run_tile(32'h3008, 16'd8, 16'd0, 16'd0, 16'd1, 16'd4, -1, 0);
    total++;
    if (timed_out != 0 || nwr != 2) begin
      bad++; $display("FAIL misal_count got writes=%0d timeout=%0d want 2/0", nwr, timed_out);
    end
    total++;
    if (wa[0] !== 32'h3000 || wbe[0] !== 16'hFF00 || wd[0] !== {32'd2, 32'd1, 64'd0}) begin
      bad++; $display("FAIL misal_w0 got %h/%h/%h want 3000/ff00/%h", wa[0], wbe[0], wd[0],
                      {32'd2, 32'd1, 64'd0});
    end
    total++;
    if (wa[1] !== 32'h3010 || wbe[1] !== 16'h00FF || wd[1] !== {64'd0, 32'd4, 32'd3}) begin
      bad++; $display("FAIL misal_w1 got %h/%h/%h want 3010/00ff/%h", wa[1], wbe[1], wd[1],
                      {64'd0, 32'd4, 32'd3});
    end
  endtask

  task automatic test_partial();
    run_tile(32'h3000, 16'd8, 16'd0, 16'd0, 16'd2, 16'd3, -1, 0);
    total++;
    if (timed_out != 0 || nwr != 2) begin
      bad++; $display("FAIL partial_count got writes=%0d timeout=%0d want 2/0", nwr, timed_out);
    end
    total++;
    if (wa[0] !== 32'h3000 || wbe[0] !== 16'h0FFF || wd[0] !== {32'd0, 32'd3, 32'd2, 32'd1}) begin
      bad++; $display("FAIL partial_w0 got %h/%h/%h", wa[0], wbe[0], wd[0]);
    end
    total++;
    if (wa[1] !== 32'h3020 || wbe[1] !== 16'h0FFF || wd[1] !== {32'd0, 32'd6, 32'd5, 32'd4}) begin
      bad++; $display("FAIL partial_w1 got %h/%h/%h", wa[1], wbe[1], wd[1]);
    end
  endtask

  task automatic test_back_pressure();
    run_tile(32'h3000, 16'd8, 16'd0, 16'd0, 16'd4, 16'd4, 1, 5);
    total++;
    if (stall_cycles != 5 || stall_viol != 0) begin
      bad++; $display("FAIL stall_hold got cycles=%0d violations=%0d want 5/0", stall_cycles, stall_viol);
    end
    total++;
    if (timed_out != 0 || nwr != 4) begin
      bad++; $display("FAIL stall_count got writes=%0d timeout=%0d want 4/0", nwr, timed_out);
    end
    for (int i = 0; i < 4 && i < nwr; i++) begin
      total++;
      if (wa[i] !== 32'h3000 + 32'(32*i) || wbe[i] !== 16'hFFFF || wd[i] !== row_word(i)) begin
        bad++; $display("FAIL stall_w%0d got %h/%h/%h want %h/ffff/%h", i, wa[i], wbe[i], wd[i],
                        32'h3000 + 32'(32*i), row_word(i));
      end
    end
  endtask

  task automatic test_zero_rows();
    run_tile(32'h3000, 16'd8, 16'd0, 16'd0, 16'd0, 16'd4, -1, 0);
    total++;
    if (timed_out != 0 || nwr != 0 || done_cnt != 1 || done_cyc != 1) begin
      bad++; $display("FAIL zero_rows got writes=%0d pulses=%0d at=%0d want 0/1 at 1",
                      nwr, done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    baseC = 32'h3000; ldc = 16'd8; row0 = 16'd0; col0 = 16'd0; rows = 16'd4; cols = 16'd4;
    tile_start = 1'b1;
    @(negedge clk);
    tile_start = 1'b0;
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (avm_write !== 1'b1) begin
      bad++; $display("FAIL rstmid_in_write got avm_write=%b want 1", avm_write);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (avm_write !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_abort got write=%b busy=%b want 0/0", avm_write, busy);
    end
    rst_n = 1'b1;
    avm_waitrequest = 1'b0;
    run_tile(32'h3000, 16'd8, 16'd0, 16'd0, 16'd2, 16'd3, -1, 0);
    total++;
    if (timed_out != 0 || nwr != 2 || wa[1] !== 32'h3020 || wd[1] !== {32'd0, 32'd6, 32'd5, 32'd4}) begin
      bad++; $display("FAIL rstmid_recover got writes=%0d addr=%h data=%h want 2/3020/%h",
                      nwr, wa[1], wd[1], {32'd0, 32'd6, 32'd5, 32'd4});
    end
  endtask

  initial begin
    rst_n = 1'b0; tile_start = 1'b0; baseC = '0; ldc = '0; row0 = '0; col0 = '0;
    rows = '0; cols = '0; in_valid = 1'b0; in_data = '0; avm_waitrequest = 1'b0;
    test_reset();
    test_aligned();
    test_col_offset();
    test_misaligned();
    test_partial();
    test_back_pressure();
    test_zero_rows();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
